// File: rtl/escalonador_ula.sv
// ---------------------------------------------------------------------------
// escalonador_ula
//
// Arbiter and sequencer that shares one ALU (ula) between two requesters.
// Each operation goes through three phases:
//   OCIOSO  - grant one valid requester and latch its op and operands
//   EXECUTA - drive the ALU from the latches and register saida/zero
//   ENTREGA - present the result to the owner until it is accepted
// An illegal op code skips EXECUTA and goes straight to ENTREGA with erro=1.
//
// Optional feature (compile-time macro):
//   ESCALONADOR_ULA_RR_EN  defined   -> round-robin arbitration on ties
//                          undefined -> fixed priority, requester 0 wins
//
// Parameters:
//   LARGURA         operand/result width in bits (default 32)
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-low reset
//   reqX_valido     in   requester X has an operation pending
//   reqX_pronto     out  requester X is accepted this cycle
//   reqX_op         in   4-bit ALU control code
//   reqX_a/_b       in   operands
//   ula_entrada1/2  out  ALU operands (0 outside EXECUTA)
//   ula_controle    out  ALU control (0000 outside EXECUTA)
//   ula_saida       in   ALU result
//   ula_zero        in   ALU zero flag
//   resX_valido     out  result for requester X is available
//   resX_dado       out  result value
//   resX_zero       out  zero flag
//   resX_erro       out  illegal op flag
//   resX_aceito     in   requester X consumes the result
// ---------------------------------------------------------------------------
module escalonador_ula #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               req0_valido,
    output logic               req0_pronto,
    input  logic [3:0]         req0_op,
    input  logic [LARGURA-1:0] req0_a,
    input  logic [LARGURA-1:0] req0_b,

    input  logic               req1_valido,
    output logic               req1_pronto,
    input  logic [3:0]         req1_op,
    input  logic [LARGURA-1:0] req1_a,
    input  logic [LARGURA-1:0] req1_b,

    output logic [LARGURA-1:0] ula_entrada1,
    output logic [LARGURA-1:0] ula_entrada2,
    output logic [3:0]         ula_controle,
    input  logic [LARGURA-1:0] ula_saida,
    input  logic               ula_zero,

    output logic               res0_valido,
    output logic [LARGURA-1:0] res0_dado,
    output logic               res0_zero,
    output logic               res0_erro,
    input  logic               res0_aceito,

    output logic               res1_valido,
    output logic [LARGURA-1:0] res1_dado,
    output logic               res1_zero,
    output logic               res1_erro,
    input  logic               res1_aceito
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    estado_t            estado;
    estado_t            proximo;

    // Latched request and registered result
    logic [3:0]         op_lat;
    logic [LARGURA-1:0] a_lat;
    logic [LARGURA-1:0] b_lat;
    logic               id_lat;
    logic [LARGURA-1:0] res_dado;
    logic               res_zero;
    logic               res_erro;

    // Arbitration
    logic               conc0;
    logic               conc1;
    logic               aceite;
    logic               id_sel;
    logic [3:0]         op_sel;
    logic [LARGURA-1:0] a_sel;
    logic [LARGURA-1:0] b_sel;
    logic               aceito_dono;

`ifdef ESCALONADOR_ULA_RR_EN
    // Requester favoured on the next tie: 0 -> req0, 1 -> req1
    logic               pref;
`endif

    // -----------------------------------------------------------------------
    // Grant logic. Only meaningful in OCIOSO; gated by reset so no requester
    // sees pronto while the block is being cleared.
    // -----------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        conc0 = 1'b0;
        conc1 = 1'b0;
        if (estado == OCIOSO && reset) begin
`ifdef ESCALONADOR_ULA_RR_EN
            if (req0_valido && req1_valido) begin
                conc0 = ~pref;
                conc1 = pref;
            end else begin
                conc0 = req0_valido;
                conc1 = req1_valido;
            end
`else
            conc0 = req0_valido;
            conc1 = req1_valido & ~req0_valido;
`endif
        end
    end

    assign req0_pronto = conc0;
    assign req1_pronto = conc1;
    assign aceite      = conc0 | conc1;
    assign id_sel      = conc1;
    assign op_sel      = conc1 ? req1_op : req0_op;
    assign a_sel       = conc1 ? req1_a  : req0_a;
    assign b_sel       = conc1 ? req1_b  : req0_b;

    // Only the owner's accept can close ENTREGA
    assign aceito_dono = id_lat ? res1_aceito : res0_aceito;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (aceite) begin
                    proximo = op_legal(op_sel) ? EXECUTA : ENTREGA;
                end
            end
            EXECUTA: proximo = ENTREGA;
            ENTREGA: begin
                if (aceito_dono) begin
                    proximo = OCIOSO;
                end
            end
            default: proximo = OCIOSO;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, latches and result register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the data latches are cleared as well, not only the control
            // state, so a reset mid-operation leaves no stale operand or result
            // that a later change to the output gating could expose.
            estado   <= OCIOSO;
            op_lat   <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            id_lat   <= 1'b0;
            res_dado <= '0;
            res_zero <= 1'b0;
            res_erro <= 1'b0;
        end else begin
            estado <= proximo;
            case (estado)
                OCIOSO: begin
                    if (aceite) begin
                        op_lat <= op_sel;
                        a_lat  <= a_sel;
                        b_lat  <= b_sel;
                        id_lat <= id_sel;
                        if (!op_legal(op_sel)) begin
                            // Illegal op bypasses the ALU with a fixed result
                            res_dado <= '0;
                            res_zero <= 1'b0;
                            res_erro <= 1'b1;
                        end
                    end
                end
                EXECUTA: begin
                    res_dado <= ula_saida;
                    res_zero <= ula_zero;
                    res_erro <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ESCALONADOR_ULA_RR_EN
    // The requester just served loses the next tie
    always_ff @(posedge clock) begin
        if (!reset) begin
            pref <= 1'b0;
        end else if (aceite) begin
            pref <= ~id_sel;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // ALU drive: only in EXECUTA, zero otherwise
    // -----------------------------------------------------------------------
    always_comb begin
        ula_entrada1 = '0;
        ula_entrada2 = '0;
        ula_controle = 4'b0000;
        if (estado == EXECUTA) begin
            ula_entrada1 = a_lat;
            ula_entrada2 = b_lat;
            ula_controle = op_lat;
        end
    end

    // -----------------------------------------------------------------------
    // Result ports: each requester sees the result only while it owns it
    // -----------------------------------------------------------------------
    always_comb begin
        res0_valido = 1'b0;
        res0_dado   = '0;
        res0_zero   = 1'b0;
        res0_erro   = 1'b0;
        res1_valido = 1'b0;
        res1_dado   = '0;
        res1_zero   = 1'b0;
        res1_erro   = 1'b0;
        if (estado == ENTREGA) begin
            if (id_lat) begin
                res1_valido = 1'b1;
                res1_dado   = res_dado;
                res1_zero   = res_zero;
                res1_erro   = res_erro;
            end else begin
                res0_valido = 1'b1;
                res0_dado   = res_dado;
                res0_zero   = res_zero;
                res0_erro   = res_erro;
            end
        end
    end

endmodule

// File: tb/tb_escalonador_ula.sv
// ---------------------------------------------------------------------------
// tb_escalonador_ula
//
// Directed testbench for escalonador_ula. A behavioural ALU answers the
// scheduler's ALU port; expected results are hand-computed constants.
// Inputs change on/just after the rising edge, outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_escalonador_ula;

    localparam int W = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valido, req0_pronto;
    logic [3:0]    req0_op;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valido, req1_pronto;
    logic [3:0]    req1_op;
    logic [W-1:0]  req1_a, req1_b;
    logic [W-1:0]  ula_entrada1, ula_entrada2, ula_saida;
    logic [3:0]    ula_controle;
    logic          ula_zero;
    logic          res0_valido, res0_zero, res0_erro, res0_aceito;
    logic [W-1:0]  res0_dado;
    logic          res1_valido, res1_zero, res1_erro, res1_aceito;
    logic [W-1:0]  res1_dado;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    escalonador_ula #(.LARGURA(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0_valido  (req0_valido),
        .req0_pronto  (req0_pronto),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valido  (req1_valido),
        .req1_pronto  (req1_pronto),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .ula_entrada1 (ula_entrada1),
        .ula_entrada2 (ula_entrada2),
        .ula_controle (ula_controle),
        .ula_saida    (ula_saida),
        .ula_zero     (ula_zero),
        .res0_valido  (res0_valido),
        .res0_dado    (res0_dado),
        .res0_zero    (res0_zero),
        .res0_erro    (res0_erro),
        .res0_aceito  (res0_aceito),
        .res1_valido  (res1_valido),
        .res1_dado    (res1_dado),
        .res1_zero    (res1_zero),
        .res1_erro    (res1_erro),
        .res1_aceito  (res1_aceito)
    );

    // Behavioural ALU
    always_comb begin
        ula_saida = '0;
        case (ula_controle)
            OP_AND:  ula_saida = ula_entrada1 & ula_entrada2;
            OP_OR:   ula_saida = ula_entrada1 | ula_entrada2;
            OP_ADD:  ula_saida = ula_entrada1 + ula_entrada2;
            OP_SUB:  ula_saida = ula_entrada1 - ula_entrada2;
            OP_SLT:  ula_saida = ($signed(ula_entrada1) < $signed(ula_entrada2)) ? W'(1) : '0;
            OP_NOR:  ula_saida = ~(ula_entrada1 | ula_entrada2);
            default: ula_saida = '0;
        endcase
        ula_zero = (ula_saida == '0);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            req0_valido = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valido = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // One complete operation from a single requester, accepted immediately.
    task automatic run_op(input int id, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_dado, input logic exp_zero,
                          input logic exp_erro);
        string t;
        t = $sformatf("r%0d_op%b", id, op);
        @(negedge clock);
        set_req(id, 1'b1, op, a, b);
        #1;
        check({t, "_pronto"}, W'(id == 0 ? req0_pronto : req1_pronto), 1);
        check({t, "_pronto_outro"}, W'(id == 0 ? req1_pronto : req0_pronto), 0);
        check({t, "_ctl_ocioso"}, W'(ula_controle), 0);
        @(posedge clock);
        #1 set_req(id, 1'b0, op, a, b);
        @(negedge clock);
        if (!exp_erro) begin
            check({t, "_ctl_exec"}, W'(ula_controle), W'(op));
            check({t, "_e1_exec"}, ula_entrada1, a);
            check({t, "_e2_exec"}, ula_entrada2, b);
            check({t, "_valido_cedo"}, W'(res0_valido | res1_valido), 0);
            @(negedge clock);
        end
        check({t, "_valido"}, W'(id == 0 ? res0_valido : res1_valido), 1);
        check({t, "_valido_outro"}, W'(id == 0 ? res1_valido : res0_valido), 0);
        check({t, "_dado"}, id == 0 ? res0_dado : res1_dado, exp_dado);
        check({t, "_zero"}, W'(id == 0 ? res0_zero : res1_zero), W'(exp_zero));
        check({t, "_erro"}, W'(id == 0 ? res0_erro : res1_erro), W'(exp_erro));
        check({t, "_ctl_entrega"}, W'(ula_controle), 0);
        if (id == 0) res0_aceito = 1'b1; else res1_aceito = 1'b1;
        @(posedge clock);
        #1 begin res0_aceito = 1'b0; res1_aceito = 1'b0; end
        @(negedge clock);
        check({t, "_valido_apos"}, W'(res0_valido | res1_valido), 0);
    endtask

    initial begin
        int grants[6];
        int ng;
        int exp_g;

        reset = 1'b0;
        set_req(0, 1'b0, OP_AND, '0, '0);
        set_req(1, 1'b0, OP_AND, '0, '0);
        res0_aceito = 1'b0;
        res1_aceito = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_res0_valido", W'(res0_valido), 0);
        check("rst_res1_valido", W'(res1_valido), 0);
        check("rst_res0_dado", res0_dado, 0);
        check("rst_ctl", W'(ula_controle), 0);
        check("rst_e1", ula_entrada1, 0);
        check("rst_pronto", W'({req1_pronto, req0_pronto}), 0);
        reset = 1'b1;

        // Basic operations
        run_op(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        run_op(1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        run_op(1, OP_SLT, 32'd3, 32'd8, 32'd1, 1'b0, 1'b0);

        // Both requesters continuously valid: six grants
        res0_aceito = 1'b1;
        res1_aceito = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, OP_ADD, 32'd2, 32'd2);
        ng = 0;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            @(negedge clock);
            if (req0_pronto || req1_pronto) begin
                check("pronto_exclusivo", W'(req0_pronto & req1_pronto), 0);
                grants[ng] = req1_pronto ? 1 : 0;
                ng++;
            end
        end
        check("n_grants", W'(ng), 6);
        @(posedge clock);
        #1 begin
            set_req(0, 1'b0, OP_ADD, '0, '0);
            set_req(1, 1'b0, OP_ADD, '0, '0);
        end
        for (int i = 0; i < ng; i++) begin
`ifdef ESCALONADOR_ULA_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            check($sformatf("grant_%0d", i), W'(grants[i]), W'(exp_g));
        end
        repeat (4) @(negedge clock);
        check("drain_idle", W'(res0_valido | res1_valido), 0);
        res0_aceito = 1'b0;
        res1_aceito = 1'b0;

        // Result held while the owner does not accept
        @(negedge clock);
        set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
        @(posedge clock);
        #1 set_req(0, 1'b0, OP_ADD, 32'd10, 32'd20);
        @(negedge clock);
        @(negedge clock);
        set_req(1, 1'b1, OP_SUB, 32'd4, 32'd1);
        res1_aceito = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("hold%0d_valido", i), W'(res0_valido), 1);
            check($sformatf("hold%0d_dado", i), res0_dado, 32'd30);
            check($sformatf("hold%0d_zero", i), W'(res0_zero), 0);
            check($sformatf("hold%0d_pronto", i), W'({req1_pronto, req0_pronto}), 0);
            check($sformatf("hold%0d_ctl", i), W'(ula_controle), 0);
            if (i < 5) @(negedge clock);
        end
        res0_aceito = 1'b1;
        res1_aceito = 1'b0;
        @(posedge clock);
        #1 res0_aceito = 1'b0;
        @(negedge clock);
        check("hold_fim_valido", W'(res0_valido), 0);
        check("hold_fim_pronto1", W'(req1_pronto), 1);
        set_req(1, 1'b0, OP_SUB, 32'd4, 32'd1);
        run_op(1, OP_SUB, 32'd4, 32'd1, 32'd3, 1'b0, 1'b0);

        // Illegal op and remaining logic functions
        run_op(0, OP_BAD, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
        run_op(0, OP_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
        run_op(1, OP_AND, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0);
        run_op(0, OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Reset during EXECUTA discards the operation
        @(negedge clock);
        set_req(0, 1'b1, OP_ADD, 32'd2, 32'd3);
        @(posedge clock);
        #1 set_req(0, 1'b0, OP_ADD, 32'd2, 32'd3);
        @(negedge clock);
        check("rstx_ctl_exec", W'(ula_controle), W'(OP_ADD));
        reset = 1'b0;
        res0_aceito = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clock);
        check("rstx_valido", W'(res0_valido | res1_valido), 0);
        check("rstx_dado", res0_dado, 0);
        check("rstx_ctl", W'(ula_controle), 0);
        check("rstx_e1", ula_entrada1, 0);
        check("rstx_pronto", W'({req1_pronto, req0_pronto}), 0);
        reset = 1'b1;
        #1;
        check("rstx_tie_pronto0", W'(req0_pronto), 1);
        check("rstx_tie_pronto1", W'(req1_pronto), 0);
        set_req(0, 1'b0, OP_ADD, '0, '0);
        set_req(1, 1'b0, OP_ADD, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("rstx_sem_pulso%0d", i), W'(res0_valido | res1_valido), 0);
        end
        res0_aceito = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
